// File: rtl/uart_pkg.sv
// uart_pkg: definitions shared by the UART serializer, receiver and TX scheduler.
//   uart_state_e    - scheduler FSM states (idle, load, send)
//   FRAME_DATA_BITS - start + 8 data + stop bits on the line per frame
//   baud_cnt_max()  - clk cycles per bit-time (integer division)
package uart_pkg;

    typedef enum logic [1:0] {
        StIdle,
        StLoad,
        StSend
    } uart_state_e;

    localparam int unsigned FRAME_DATA_BITS = 10;

    function automatic int unsigned baud_cnt_max(input int unsigned clk_freq,
                                                 input int unsigned uart_bps);
        return clk_freq / uart_bps;
    endfunction

endpackage

// File: rtl/uart_rr_pick.sv
// uart_rr_pick: combinational rotate-priority picker.
//   req    (in)  per-channel request vector
//   rr_ptr (in)  channel that has highest priority this round
//   winner (out) index of the first set request scanning rr_ptr, rr_ptr+1, ...
//   valid  (out) at least one request is set
// Macro UART_SCHED_FIXED_PRIO_EN: lowest set index wins and rr_ptr is ignored.
module uart_rr_pick #(
    parameter int unsigned NUM_REQ = 4,
    localparam int unsigned IDX_W  = $clog2(NUM_REQ)
) (
    input  logic [NUM_REQ-1:0] req,
    input  logic [IDX_W-1:0]   rr_ptr,
    output logic [IDX_W-1:0]   winner,
    output logic               valid
);

    assign valid = |req;

`ifdef UART_SCHED_FIXED_PRIO_EN
    logic unused_rr_ptr;
    assign unused_rr_ptr = ^rr_ptr;

    // Descending scan: the last hit, i.e. the lowest index, wins.
    always_comb begin
        winner = '0;
        for (int i = int'(NUM_REQ) - 1; i >= 0; i--) begin
            if (req[IDX_W'(i)]) begin
                winner = IDX_W'(i);
            end
        end
    end
`else
    int unsigned        idx;
    logic [IDX_W-1:0]   sel;

    // Scan offsets from far to near so the channel closest to rr_ptr wins.
    always_comb begin
        winner = '0;
        idx    = 0;
        sel    = '0;
        for (int i = int'(NUM_REQ) - 1; i >= 0; i--) begin
            idx = (32'(rr_ptr) + $unsigned(i)) % NUM_REQ;
            sel = IDX_W'(idx);
            if (req[sel]) begin
                winner = sel;
            end
        end
    end
`endif

endmodule

// File: rtl/uart_tx_sched.sv
// uart_tx_sched: shares one UART TX serializer between NUM_REQ byte producers.
// The serializer has no busy output and samples its data input live, so this
// block times every frame itself and holds tx_data for the whole frame.
//   clk      (in)  system clock
//   rst      (in)  synchronous reset, active-high
//   req      (in)  per-channel request level, held until ack
//   req_data (in)  channel i byte at [8*i+7:8*i]
//   ack      (out) one-cycle pulse: that channel's byte has been captured
//   tx_flag  (out) one-cycle start pulse to the serializer
//   tx_data  (out) byte to the serializer, stable for the frame
//   busy     (out) high while loading / sending a frame
//   grant_id (out) index of the channel being served
// Macro UART_SCHED_FIXED_PRIO_EN: fixed priority (lowest index), no rr_ptr.
module uart_tx_sched
    import uart_pkg::*;
#(
    parameter int unsigned NUM_REQ    = 4,
    parameter int unsigned UART_BPS   = 'd9600,
    parameter int unsigned CLK_FREQ   = 'd50_000_000,
    parameter int unsigned GUARD_BITS = 1,
    localparam int unsigned IDX_W     = $clog2(NUM_REQ)
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic [NUM_REQ-1:0]   req,
    input  logic [8*NUM_REQ-1:0] req_data,
    output logic [NUM_REQ-1:0]   ack,
    output logic                 tx_flag,
    output logic [7:0]           tx_data,
    output logic                 busy,
    output logic [IDX_W-1:0]     grant_id
);

    localparam int unsigned BAUD_CNT_MAX = baud_cnt_max(CLK_FREQ, UART_BPS);
    localparam int unsigned FRAME_CYCLES = BAUD_CNT_MAX * (FRAME_DATA_BITS + GUARD_BITS);
    localparam int unsigned CNT_W        = $clog2(FRAME_CYCLES);
    localparam logic [CNT_W-1:0] FRAME_LAST = CNT_W'(FRAME_CYCLES - 1);
    localparam logic [IDX_W-1:0] LAST_ID    = IDX_W'(NUM_REQ - 1);

    uart_state_e        state_q, state_d;
    logic [NUM_REQ-1:0] ack_q, ack_d;
    logic               tx_flag_q, tx_flag_d;
    logic [7:0]         tx_data_q, tx_data_d;
    logic               busy_q, busy_d;
    logic [IDX_W-1:0]   grant_q, grant_d;
    logic [CNT_W-1:0]   frame_cnt_q, frame_cnt_d;

    logic [IDX_W-1:0]   rr_ptr;
    logic [IDX_W-1:0]   pick_id;
    logic               pick_valid;

    uart_rr_pick #(
        .NUM_REQ (NUM_REQ)
    ) u_pick (
        .req    (req),
        .rr_ptr (rr_ptr),
        .winner (pick_id),
        .valid  (pick_valid)
    );

`ifdef UART_SCHED_FIXED_PRIO_EN
    assign rr_ptr = '0;
`else
    logic [IDX_W-1:0] rr_ptr_q, rr_ptr_d;

    assign rr_ptr = rr_ptr_q;

    always_ff @(posedge clk) begin
        if (rst) begin
            rr_ptr_q <= '0;
        end else begin
            rr_ptr_q <= rr_ptr_d;
        end
    end
`endif

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q     <= StIdle;
            ack_q       <= '0;
            tx_flag_q   <= 1'b0;
            tx_data_q   <= 8'h00;
            busy_q      <= 1'b0;
            grant_q     <= '0;
            frame_cnt_q <= '0;
        end else begin
            state_q     <= state_d;
            ack_q       <= ack_d;
            tx_flag_q   <= tx_flag_d;
            tx_data_q   <= tx_data_d;
            busy_q      <= busy_d;
            grant_q     <= grant_d;
            frame_cnt_q <= frame_cnt_d;
        end
    end

    always_comb begin
        state_d     = state_q;
        ack_d       = '0;
        tx_flag_d   = 1'b0;
        tx_data_d   = tx_data_q;
        busy_d      = busy_q;
        grant_d     = grant_q;
        frame_cnt_d = frame_cnt_q;
`ifndef UART_SCHED_FIXED_PRIO_EN
        rr_ptr_d    = rr_ptr_q;
`endif
        unique case (state_q)
            StIdle: begin
                if (pick_valid) begin
                    ack_d[pick_id] = 1'b1;
                    tx_data_d      = req_data[{pick_id, 3'b000} +: 8];
                    grant_d        = pick_id;
                    busy_d         = 1'b1;
                    state_d        = StLoad;
                end
            end
            StLoad: begin
                tx_flag_d   = 1'b1;
                frame_cnt_d = '0;
                state_d     = StSend;
            end
            StSend: begin
                frame_cnt_d = frame_cnt_q + 1'b1;
                if (frame_cnt_q == FRAME_LAST) begin
                    state_d = StIdle;
                    busy_d  = 1'b0;
`ifndef UART_SCHED_FIXED_PRIO_EN
                    // Served channel drops to lowest priority next round.
                    rr_ptr_d = (grant_q == LAST_ID) ? '0 : grant_q + 1'b1;
`endif
                end
            end
            default: state_d = StIdle;
        endcase
    end

    assign ack      = ack_q;
    assign tx_flag  = tx_flag_q;
    assign tx_data  = tx_data_q;
    assign busy     = busy_q;
    assign grant_id = grant_q;

endmodule

// File: tb/tb_uart_tx_sched.sv
module tb_uart_tx_sched;

    localparam int NREQ  = 4;
    localparam int CLKF  = 1_000_000;
    localparam int BPS   = 100_000;
    localparam int GUARD = 1;
    localparam int BAUD  = CLKF / BPS;
    localparam int FRAME = BAUD * (10 + GUARD);

    logic        clk = 1'b0;
    logic        rst;
    logic [3:0]  req;
    logic [31:0] req_data;
    logic [3:0]  ack;
    logic        tx_flag;
    logic [7:0]  tx_data;
    logic        busy;
    logic [1:0]  grant_id;

    uart_tx_sched #(
        .NUM_REQ    (NREQ),
        .UART_BPS   (BPS),
        .CLK_FREQ   (CLKF),
        .GUARD_BITS (GUARD)
    ) dut (
        .clk      (clk),
        .rst      (rst),
        .req      (req),
        .req_data (req_data),
        .ack      (ack),
        .tx_flag  (tx_flag),
        .tx_data  (tx_data),
        .busy     (busy),
        .grant_id (grant_id)
    );

    always #5 clk = ~clk;

    int total = 0;
    int bad   = 0;
    int cyc   = 0;
    bit live  = 0;

    task automatic chk(input string name, input logic [31:0] got, input logic [31:0] want);
        total++;
        if (got !== want) begin
            bad++;
            $display("FAIL %s got=%0h want=%0h (cycle %0d)", name, got, want, cyc);
        end
    endtask

    // ---------------- behavioural model ----------------
    // A grant opens a window of FRAME+2 edges: ack edge, start edge, FRAME send edges.
    // Edges since the grant decide every output; the next grant may come at FRAME+2.
    bit         m_active = 0;
    int         m_since  = 0;
    int         m_ptr    = 0;
    logic [3:0] exp_ack;
    logic       exp_flag;
    logic [7:0] exp_data;
    logic       exp_busy;
    logic [1:0] exp_gid;

    function automatic int pick(input logic [3:0] r, input int ptr);
`ifdef UART_SCHED_FIXED_PRIO_EN
        for (int k = 0; k < NREQ; k++) if (r[k]) return k;
`else
        for (int k = 0; k < NREQ; k++) if (r[(ptr + k) % NREQ]) return (ptr + k) % NREQ;
`endif
        return 0;
    endfunction

    task automatic model_step();
        int w;
        if (rst) begin
            m_active = 0;
            m_since  = 0;
            m_ptr    = 0;
            exp_ack  = 4'b0;
            exp_flag = 1'b0;
            exp_data = 8'h00;
            exp_busy = 1'b0;
            exp_gid  = 2'd0;
            live     = 1;
            return;
        end
        if (m_active) begin
            m_since++;
            if (m_since == FRAME + 1) m_ptr = (int'(exp_gid) + 1) % NREQ;
            if (m_since == FRAME + 2) m_active = 0;
        end
        if (!m_active && req != 4'b0) begin
            w        = pick(req, m_ptr);
            m_active = 1;
            m_since  = 0;
            exp_gid  = 2'(w);
            exp_data = req_data[8*w +: 8];
        end
        exp_ack  = (m_active && m_since == 0) ? 4'(1 << exp_gid) : 4'b0;
        exp_flag = m_active && m_since == 1;
        exp_busy = m_active && m_since <= FRAME;
    endtask

    initial forever begin
        @(posedge clk);
        cyc++;
        model_step();
    end

    // ---------------- compare + observation ----------------
    int         ack_cyc_q[$];
    int         ack_id_q[$];
    int         busy_fall_q[$];
    int         line_q[$];
    logic [3:0] ack_or = 4'b0;
    bit         prev_busy = 0;
    bit         ser_on = 0;
    int         ser_off = 0;
    logic [7:0] ser_byte = 8'h00;

    initial forever begin
        @(negedge clk);
        if (live) begin
            chk("ack", ack, exp_ack);
            chk("tx_flag", tx_flag, exp_flag);
            chk("tx_data", tx_data, exp_data);
            chk("busy", busy, exp_busy);
            chk("grant_id", grant_id, exp_gid);
        end
        if (ack != 4'b0) begin
            ack_cyc_q.push_back(cyc);
            ack_id_q.push_back(int'(grant_id));
            ack_or |= ack;
        end
        if (prev_busy && !busy) busy_fall_q.push_back(cyc);
        prev_busy = busy;
        // Line-side view: data bit b is sampled live at the middle of bit-time b+1.
        if (tx_flag) begin
            ser_on   = 1;
            ser_off  = 0;
            ser_byte = 8'h00;
        end else if (ser_on) begin
            ser_off++;
            if (!busy) begin
                ser_on = 0;
            end else begin
                if (ser_off >= BAUD + BAUD/2 && ser_off <= 8*BAUD + BAUD/2
                    && (ser_off - BAUD/2) % BAUD == 0)
                    ser_byte[(ser_off - BAUD/2) / BAUD - 1] = tx_data[(ser_off - BAUD/2) / BAUD - 1];
                if (ser_off == 10 * BAUD) begin
                    line_q.push_back(int'(ser_byte));
                    ser_on = 0;
                end
            end
        end
    end

    // ---------------- stimulus helpers ----------------
    task automatic clear_logs();
        ack_cyc_q.delete();
        ack_id_q.delete();
        busy_fall_q.delete();
        line_q.delete();
        ack_or = 4'b0;
    endtask

    task automatic do_reset();
        rst = 1'b1;
        repeat (2) @(negedge clk);
        rst = 1'b0;
    endtask

    task automatic wait_ack(input int ch, input int budget);
        bit seen = 0;
        for (int n = 0; n < budget && !seen; n++) begin
            @(negedge clk);
            if (ack[2'(ch)]) seen = 1;
        end
        if (!seen) chk($sformatf("ack%0d_timeout", ch), 32'd0, 32'd1);
    endtask

    task automatic wait_any_ack(input int budget);
        bit seen = 0;
        for (int n = 0; n < budget && !seen; n++) begin
            @(negedge clk);
            if (ack != 4'b0) seen = 1;
        end
        if (!seen) chk("any_ack_timeout", 32'd0, 32'd1);
    endtask

    task automatic wait_idle(input int budget);
        bit seen = 0;
        for (int n = 0; n < budget && !seen; n++) begin
            @(negedge clk);
            if (!busy) seen = 1;
        end
        if (!seen) chk("idle_timeout", 32'd0, 32'd1);
        repeat (4) @(negedge clk);
    endtask

    task automatic chk_q(input string name, input int got[$], input int want[$]);
        chk({name, "_count"}, got.size(), want.size());
        for (int i = 0; i < want.size(); i++)
            if (i < got.size()) chk($sformatf("%s[%0d]", name, i), got[i], want[i]);
    endtask

    task automatic chk_gaps(input string name, input int q[$], input int gap);
        for (int i = 1; i < q.size(); i++)
            chk($sformatf("%s[%0d]", name, i), q[i] - q[i-1], gap);
    endtask

    // ---------------- directed tests ----------------
    initial begin
        int e[$];
        int t_req;
        rst      = 1'b1;
        req      = 4'b0;
        req_data = 32'h0;
        repeat (3) @(negedge clk);
        chk("rst_ack", ack, 4'b0);
        chk("rst_flag", tx_flag, 1'b0);
        chk("rst_data", tx_data, 8'h00);
        chk("rst_busy", busy, 1'b0);
        chk("rst_grant", grant_id, 2'd0);
        rst = 1'b0;
        @(negedge clk);

        // 1: single request on channel 2
        clear_logs();
        req_data = 32'h00A5_0000;
        req      = 4'b0100;
        t_req    = cyc;
        wait_ack(2, 5);
        chk("t1_ack", ack, 4'b0100);
        chk("t1_data", tx_data, 8'hA5);
        req = 4'b0;
        @(negedge clk);
        chk("t1_flag", tx_flag, 1'b1);
        wait_idle(200);
        if (ack_cyc_q.size() > 0) chk("t1_latency", ack_cyc_q[0] - t_req, 1);
        if (ack_cyc_q.size() > 0 && busy_fall_q.size() > 0)
            chk("t1_busy_len", busy_fall_q[0] - ack_cyc_q[0], 111);
        e = '{32'hA5};
        chk_q("t1_line", line_q, e);

`ifndef UART_SCHED_FIXED_PRIO_EN
        // 2: all four requesting continuously
        do_reset();
        clear_logs();
        req_data = 32'h4433_2211;
        req      = 4'b1111;
        for (int k = 0; k < 5; k++) wait_any_ack(150);
        req = 4'b0;
        wait_idle(200);
        e = '{0, 1, 2, 3, 0};
        chk_q("t2_ids", ack_id_q, e);
        chk_gaps("t2_gap", ack_cyc_q, 112);
        e = '{32'h11, 32'h22, 32'h33, 32'h44, 32'h11};
        chk_q("t2_line", line_q, e);

        // 3: channels 0 and 3 after channel 0 was served
        clear_logs();
        req = 4'b1001;
        for (int k = 0; k < 3; k++) wait_any_ack(150);
        req = 4'b0;
        wait_idle(200);
        e = '{3, 0, 3};
        chk_q("t3_ids", ack_id_q, e);
        e = '{32'h44, 32'h11, 32'h44};
        chk_q("t3_line", line_q, e);

        // 4: request rising mid-frame waits for the frame to end
        clear_logs();
        req = 4'b0010;
        wait_ack(1, 5);
        req = 4'b0;
        repeat (52) @(negedge clk);
        req = 4'b0100;
        wait_ack(2, 150);
        req = 4'b0;
        wait_idle(200);
        e = '{1, 2};
        chk_q("t4_ids", ack_id_q, e);
        chk_gaps("t4_gap", ack_cyc_q, 112);

        // 5: reset at frame cycle 30 aborts; pending request served from pointer 0
        clear_logs();
        req = 4'b0010;
        wait_ack(1, 5);
        req = 4'b1010;
        repeat (32) @(negedge clk);
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        chk("t5_rst_busy", busy, 1'b0);
        chk("t5_rst_data", tx_data, 8'h00);
        chk("t5_rst_flag", tx_flag, 1'b0);
        chk("t5_rst_grant", grant_id, 2'd0);
        @(negedge clk);
        chk("t5_regrant_ack", ack, 4'b0010);
        chk("t5_regrant_data", tx_data, 8'h22);
        req = 4'b0;
        wait_idle(200);
        e = '{1, 1};
        chk_q("t5_ids", ack_id_q, e);
        e = '{32'h22};
        chk_q("t5_line", line_q, e);
`else
        // 6: fixed priority, channel 3 starves behind channel 1
        do_reset();
        clear_logs();
        req_data = 32'h4433_2211;
        req      = 4'b1010;
        for (int k = 0; k < 3; k++) wait_any_ack(150);
        req = 4'b0;
        wait_idle(200);
        e = '{1, 1, 1};
        chk_q("t6_ids", ack_id_q, e);
        chk("t6_ch3_never", ack_or[3], 1'b0);
        e = '{32'h22, 32'h22, 32'h22};
        chk_q("t6_line", line_q, e);
`endif

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

    initial begin
        #1_000_000;
        $display("FAIL watchdog expired at cycle %0d", cyc);
        $fatal(1, "watchdog");
    end

endmodule

// File: doc/uart_tx_sched.md
Name: uart_tx_sched

Overview:
Round-robin scheduler that shares one UART transmitter between NUM_REQ byte producers. Sits between client logic and the UART TX serializer.
- Drives the serializer's one-cycle start pulse (tx_flag) and byte bus (tx_data).
- The serializer has no busy output, so this block times each frame itself.
- Holds tx_data stable for the whole frame, because the serializer samples its data input live, bit by bit.

Parameters:
NUM_REQ, 4, number of requesting channels (2..8)
UART_BPS, 'd9600, line baud rate; must match the serializer instance
CLK_FREQ, 'd50_000_000, clk frequency in Hz; must match the serializer instance
GUARD_BITS, 1, extra idle bit-times appended after each 10-bit frame

Ports:
clk  input  1  system clock
rst  input  1  synchronous reset, active-high
req  input  NUM_REQ  per-channel request level; held until ack
req_data  input  8*NUM_REQ  channel i byte at [8*i+7:8*i]; stable while req[i]=1
ack  output  NUM_REQ  one-cycle pulse; byte of that channel has been captured
tx_flag  output  1  one-cycle start pulse to the serializer
tx_data  output  8  byte to the serializer; held for the whole frame
busy  output  1  high in LOAD and SEND states
grant_id  output  clog2(NUM_REQ)  index of the channel currently served

Behaviour:
- Constants:
  - BAUD_CNT_MAX = CLK_FREQ/UART_BPS (integer division).
  - FRAME_CYCLES = BAUD_CNT_MAX*(10+GUARD_BITS).
  - Frame counter width = clog2(FRAME_CYCLES).
- Reset (rst=1 at a clk edge): state=IDLE, ack=0, tx_flag=0, tx_data=8'h00, busy=0, grant_id=0, rr_ptr=0, frame_cnt=0. Reset mid-frame aborts immediately; no ack and no tx_flag follow.
- All outputs are registered.
- State IDLE:
  - If any req bit is set, pick the winner: first set bit scanning rr_ptr, rr_ptr+1, … modulo NUM_REQ.
  - At that edge: ack[winner]<=1 for one cycle, tx_data<=winner's byte, grant_id<=winner, busy<=1, state<=LOAD.
  - If no request is set, stay in IDLE.
- State LOAD (1 cycle): tx_flag<=1 for one cycle, frame_cnt<=0, state<=SEND.
- State SEND:
  - frame_cnt increments every cycle.
  - When frame_cnt==FRAME_CYCLES-1: state<=IDLE, busy<=0, rr_ptr<=(grant_id+1) mod NUM_REQ.
  - tx_data and grant_id are unchanged throughout SEND.
- Latency:
  - req[i] sampled high in IDLE at edge E: ack[i] and tx_data valid after E; tx_flag high after E+1.
  - The next grant's ack occurs no earlier than FRAME_CYCLES+2 cycles after the previous ack.
- Back-to-back: a requester may keep req high after ack to send a new byte. It is rescheduled by round-robin order, so it is not served twice in a row if another channel is requesting.
- Requests that arrive during LOAD or SEND are ignored until IDLE. No request is ever dropped while req stays high.
- A req deasserted before ack is simply not served; no error is flagged.
- rr_ptr wraps from NUM_REQ-1 to 0.
- The ack pulse and the winner's req are coincident for one cycle. The requester must drop req, or change data, only after seeing ack.

Optional Feature:
Macro: UART_SCHED_FIXED_PRIO_EN.
- Defined: fixed priority; the lowest set index wins; rr_ptr is not implemented; starvation of high indices is permitted.
- Undefined (default): round-robin as above.

Decomposition:
- Shared package uart_pkg holds:
  - the state enum (IDLE, LOAD, SEND);
  - FRAME_DATA_BITS=10;
  - a BAUD_CNT_MAX calculation function, reused by the serializer and receiver.
- One sub-module, uart_rr_pick: combinational rotate-priority picker. Inputs are req vector and rr_ptr; outputs are winner index and a valid flag. The fixed-priority variant is selected inside it via the macro.

Test Plan:
Bench parameters: NUM_REQ=4, CLK_FREQ=1_000_000, UART_BPS=100_000, GUARD_BITS=1, so FRAME_CYCLES=110.
1. Single request: req=4'b0100, byte 8'hA5.
   - ack=4'b0100 one cycle later; tx_flag pulse the next cycle; tx_data=8'hA5 stable for 110 cycles.
   - Serializer line decodes 0xA5; busy drops 111 cycles after ack.
2. All four requesting continuously with bytes 8'h11/22/33/44.
   - Grant order 0,1,2,3,0.
   - Ack spacing exactly 112 cycles.
   - Serialized bytes 11,22,33,44,11.
3. req=4'b1001 after channel 0 served.
   - Channel 3 wins next: rr_ptr=1, scan 1,2,3.
   - Then channel 0, then channel 3.
4. Request arrives mid-SEND: req[2] rises at cycle 50 of the frame.
   - No ack until the frame ends.
   - ack[2] on the first IDLE edge after the frame.
5. rst=1 for 1 cycle at frame cycle 30.
   - All outputs equal their reset values next cycle; no tx_flag follows.
   - Pending req then served from rr_ptr=0.
6. With UART_SCHED_FIXED_PRIO_EN defined, req=4'b1010 held continuously.
   - Channel 1 granted every frame; channel 3 never acked.
